// File: rtl/ts_queue_arb.sv
// Timestamp readout scheduler: rx/tx record FIFOs, round-robin arbitration onto one valid/ready port.
// Optional macro TS_EVENT_FILTER_EN: enqueue only PTP event messages (messageType 0..3).
module ts_queue_arb #(
    parameter int DEPTH_LOG2 = 2,
    parameter int DROP_W     = 8
) (
    input  logic                  rtc_clk,
    input  logic                  rtc_rst,
    input  logic                  flush_i,
    input  logic                  int_en_i,
    input  logic                  rx_ts_stb_i,
    input  logic [79:0]           rx_timestamp_i,
    input  logic [15:0]           rx_frac_ns_i,
    input  logic [15:0]           rx_seqId_i,
    input  logic [3:0]            rx_messageType_i,
    input  logic                  tx_ts_stb_i,
    input  logic [79:0]           tx_timestamp_i,
    input  logic [15:0]           tx_frac_ns_i,
    input  logic [15:0]           tx_seqId_i,
    input  logic [3:0]            tx_messageType_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  rd_dir_o,
    output logic [79:0]           rd_timestamp_o,
    output logic [15:0]           rd_frac_ns_o,
    output logic [15:0]           rd_seqId_o,
    output logic [3:0]            rd_messageType_o,
    output logic [DEPTH_LOG2:0]   rx_level_o,
    output logic [DEPTH_LOG2:0]   tx_level_o,
    output logic [DROP_W-1:0]     rx_drop_cnt_o,
    output logic [DROP_W-1:0]     tx_drop_cnt_o,
    output logic                  int_ts_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic [79:0] ts;
        logic [15:0] frac;
        logic [15:0] seq;
        logic [3:0]  mtype;
    } rec_t;

    typedef enum logic {S_EMPTY, S_HOLD} st_t;

    st_t                 state, state_nxt;
    rec_t                in_rec [2];
    rec_t                mem    [2][DEPTH];
    rec_t                out_rec;
    logic [DEPTH_LOG2:0] wptr [2];
    logic [DEPTH_LOG2:0] rptr [2];
    logic [DROP_W-1:0]   drop_cnt [2];
    logic [1:0]          stb, ev_ok, full, nempty, push, pop, drop;
    logic                load, gnt, last_grant, out_dir;

    // index 0 = rx, 1 = tx throughout
    always_comb begin
        in_rec[0] = '{rx_timestamp_i, rx_frac_ns_i, rx_seqId_i, rx_messageType_i};
        in_rec[1] = '{tx_timestamp_i, tx_frac_ns_i, tx_seqId_i, tx_messageType_i};
        stb       = {tx_ts_stb_i, rx_ts_stb_i};
        for (int d = 0; d < 2; d++) begin
`ifdef TS_EVENT_FILTER_EN
            ev_ok[d]  = (in_rec[d].mtype[3:2] == 2'b00);
`else
            ev_ok[d]  = 1'b1;
`endif
            nempty[d] = (wptr[d] != rptr[d]);
            full[d]   = (wptr[d] == {~rptr[d][DEPTH_LOG2], rptr[d][DEPTH_LOG2-1:0]});
        end
    end

    // Arbitration only sees FIFO contents as of the previous edge: no bypass.
    always_comb begin
        load = (state == S_EMPTY) || rd_ready_i;
        gnt  = (nempty == 2'b11) ? ~last_grant : nempty[1];
        pop[0] = load & nempty[0] & ~gnt & ~flush_i;
        pop[1] = load & nempty[1] &  gnt & ~flush_i;
        for (int d = 0; d < 2; d++) begin
            push[d] = stb[d] & ev_ok[d] & ~flush_i & (~full[d] | pop[d]);
            drop[d] = stb[d] & ev_ok[d] & ~flush_i &  full[d] & ~pop[d];
        end
        state_nxt = state;
        if (flush_i)
            state_nxt = S_EMPTY;
        else if (load)
            state_nxt = (|nempty) ? S_HOLD : S_EMPTY;
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) state <= S_EMPTY;
        else         state <= state_nxt;
    end

    always_ff @(posedge rtc_clk) begin
        for (int d = 0; d < 2; d++)
            if (push[d]) mem[d][wptr[d][DEPTH_LOG2-1:0]] <= in_rec[d];
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            for (int d = 0; d < 2; d++) begin
                wptr[d]     <= '0;
                rptr[d]     <= '0;
                drop_cnt[d] <= '0;
            end
            last_grant <= 1'b1;
            out_dir    <= 1'b0;
            out_rec    <= '0;
        end else if (flush_i) begin
            for (int d = 0; d < 2; d++) begin
                wptr[d]     <= '0;
                rptr[d]     <= '0;
                drop_cnt[d] <= '0;
            end
            last_grant <= 1'b1;
            out_dir    <= 1'b0;
            out_rec    <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (push[d]) wptr[d] <= wptr[d] + (DEPTH_LOG2+1)'(1);
                if (pop[d])  rptr[d] <= rptr[d] + (DEPTH_LOG2+1)'(1);
                if (drop[d] && drop_cnt[d] != '1)
                    drop_cnt[d] <= drop_cnt[d] + DROP_W'(1);
            end
            if (|pop) begin
                last_grant <= pop[1];
                out_dir    <= pop[1];
                out_rec    <= pop[1] ? mem[1][rptr[1][DEPTH_LOG2-1:0]]
                                     : mem[0][rptr[0][DEPTH_LOG2-1:0]];
            end
        end
    end

    assign rd_valid_o       = (state == S_HOLD);
    assign rd_dir_o         = out_dir;
    assign rd_timestamp_o   = out_rec.ts;
    assign rd_frac_ns_o     = out_rec.frac;
    assign rd_seqId_o       = out_rec.seq;
    assign rd_messageType_o = out_rec.mtype;
    assign rx_level_o       = wptr[0] - rptr[0];
    assign tx_level_o       = wptr[1] - rptr[1];
    assign rx_drop_cnt_o    = drop_cnt[0];
    assign tx_drop_cnt_o    = drop_cnt[1];
    assign int_ts_o         = rd_valid_o & int_en_i;
endmodule

// File: tb/tb_ts_queue_arb.sv
// Directed bench for ts_queue_arb: latency, arbitration order, full/drop, saturation, flush, filter.
module tb_ts_queue_arb;
    logic        clk = 1'b0;
    logic        rst, flush, int_en;
    logic        rx_stb, tx_stb, rd_ready;
    logic [79:0] rx_ts, tx_ts;
    logic [15:0] rx_frac, tx_frac, rx_seq, tx_seq;
    logic [3:0]  rx_type, tx_type;
    logic        rd_valid, rd_dir, int_ts;
    logic [79:0] rd_ts;
    logic [15:0] rd_frac, rd_seq;
    logic [3:0]  rd_type;
    logic [2:0]  rx_level, tx_level;
    logic [7:0]  rx_drop, tx_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ts_queue_arb dut (
        .rtc_clk(clk), .rtc_rst(rst), .flush_i(flush), .int_en_i(int_en),
        .rx_ts_stb_i(rx_stb), .rx_timestamp_i(rx_ts), .rx_frac_ns_i(rx_frac),
        .rx_seqId_i(rx_seq), .rx_messageType_i(rx_type),
        .tx_ts_stb_i(tx_stb), .tx_timestamp_i(tx_ts), .tx_frac_ns_i(tx_frac),
        .tx_seqId_i(tx_seq), .tx_messageType_i(tx_type),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_dir_o(rd_dir),
        .rd_timestamp_o(rd_ts), .rd_frac_ns_o(rd_frac), .rd_seqId_o(rd_seq),
        .rd_messageType_o(rd_type),
        .rx_level_o(rx_level), .tx_level_o(tx_level),
        .rx_drop_cnt_o(rx_drop), .tx_drop_cnt_o(tx_drop), .int_ts_o(int_ts)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 0; int_en = 0; rx_stb = 0; tx_stb = 0; rd_ready = 0;
        rx_ts = '0; tx_ts = '0; rx_frac = '0; tx_frac = '0;
        rx_seq = '0; tx_seq = '0; rx_type = '0; tx_type = '0;
        #3;
        chk("rst_valid", rd_valid, 0);
        chk("rst_rxlvl", rx_level, 0);
        chk("rst_fields", {rd_dir, rd_ts, rd_frac, rd_seq, rd_type}, 0);
        chk("rst_drops", {rx_drop, tx_drop}, 0);
        tick();
        rst = 1'b0;

        // single rx record, latency and hold
        rx_stb = 1; rx_ts = 80'h000000000005_3B9AC9FF; rx_frac = 16'h1234;
        rx_seq = 16'h0007; rx_type = 4'h0;
        tick();
        rx_stb = 0;
        chk("lat_n_valid", rd_valid, 0);
        chk("lat_n_rxlvl", rx_level, 1);
        tick();
        chk("lat_n1_valid", rd_valid, 1);
        chk("lat_dir", rd_dir, 0);
        chk("lat_fields", {rd_ts, rd_frac, rd_seq, rd_type},
            {80'h000000000005_3B9AC9FF, 16'h1234, 16'h0007, 4'h0});
        chk("int_off", int_ts, 0);
        int_en = 1; #1;
        chk("int_on", int_ts, 1);
        tick(); tick();
        chk("hold_valid", rd_valid, 1);
        chk("hold_seq", rd_seq, 16'h0007);
        rd_ready = 1;
        tick();
        chk("drain_valid", rd_valid, 0);
        chk("int_idle", int_ts, 0);

        // paired strobes: rx first, then strict alternation
        do_reset();
        rd_ready = 1;
        rx_stb = 1; tx_stb = 1; rx_seq = 16'h0010; tx_seq = 16'h0020;
        tick();
        rx_stb = 0; tx_stb = 0;
        tick();
        chk("pair_first", {rd_valid, rd_dir, rd_seq}, {1'b1, 1'b0, 16'h0010});
        tick();
        chk("pair_second", {rd_valid, rd_dir, rd_seq}, {1'b1, 1'b1, 16'h0020});
        tick();
        chk("pair_empty", rd_valid, 0);
        for (int c = 0; c < 10; c++) begin
            rx_stb = (c < 4); tx_stb = (c < 4);
            rx_seq = 16'h0011 + 16'(c); tx_seq = 16'h0021 + 16'(c);
            tick();
            if (c >= 1 && c <= 8) begin
                automatic int  i  = c - 1;
                automatic logic d = i[0];
                automatic logic [15:0] s = (d ? 16'h0021 : 16'h0011) + 16'(i / 2);
                chk($sformatf("alt%0d", i), {rd_valid, rd_dir, rd_seq}, {1'b1, d, s});
            end
        end
        rx_stb = 0; tx_stb = 0;
        chk("alt_end", rd_valid, 0);

        // overflow: 6 rx strobes, ready low
        do_reset();
        rd_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            rx_stb = 1; rx_seq = 16'(k);
            tick();
        end
        rx_stb = 0;
        chk("ovf_level", rx_level, 4);
        chk("ovf_drop", rx_drop, 1);
        chk("ovf_head", {rd_valid, rd_seq}, {1'b1, 16'h0001});

        // full with simultaneous pop: accepted, no drop
        rd_ready = 1; rx_stb = 1; rx_seq = 16'h0009;
        tick();
        rd_ready = 0; rx_stb = 0;
        chk("fullpop_level", rx_level, 4);
        chk("fullpop_drop", rx_drop, 1);
        chk("fullpop_head", rd_seq, 16'h0002);
        rd_ready = 1;
        begin
            logic [15:0] exp_q [4] = '{16'h3, 16'h4, 16'h5, 16'h9};
            for (int i = 0; i < 4; i++) begin
                tick();
                chk($sformatf("order%0d", i), {rd_valid, rd_seq}, {1'b1, exp_q[i]});
            end
        end
        tick();
        chk("order_end", rd_valid, 0);

        // drop saturation, then flush with a tx strobe
        do_reset();
        rd_ready = 0;
        for (int k = 0; k < 305; k++) begin
            rx_stb = 1; rx_seq = 16'(k);
            tick();
            if (k == 258) chk("drop_254", rx_drop, 254);
        end
        rx_stb = 0;
        chk("drop_sat", rx_drop, 255);
        chk("sat_level", rx_level, 4);
        flush = 1; tx_stb = 1; tx_seq = 16'h00AA;
        tick();
        flush = 0; tx_stb = 0;
        chk("flush_levels", {rx_level, tx_level}, 0);
        chk("flush_drops", {rx_drop, tx_drop}, 0);
        chk("flush_valid", rd_valid, 0);
        rd_ready = 1;
        tick();
        chk("flush_noq", {rd_valid, tx_level}, 0);

        // event-type filter
        rx_stb = 1; rx_type = 4'h8; rx_seq = 16'h0030;
        tick();
        rx_type = 4'h1; rx_seq = 16'h0031;
        tick();
        rx_stb = 0;
`ifdef TS_EVENT_FILTER_EN
        chk("filt_first", rd_valid, 0);
        tick();
        chk("filt_second", {rd_valid, rd_seq, rd_type}, {1'b1, 16'h0031, 4'h1});
        tick();
        chk("filt_end", rd_valid, 0);
`else
        chk("nofilt_first", {rd_valid, rd_seq, rd_type}, {1'b1, 16'h0030, 4'h8});
        tick();
        chk("nofilt_second", {rd_valid, rd_seq, rd_type}, {1'b1, 16'h0031, 4'h1});
        tick();
        chk("nofilt_end", rd_valid, 0);
`endif
        chk("filt_drops", {rx_drop, tx_drop}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ts_queue_arb.md
Name: ts_queue_arb

Overview:
- Timestamp readout scheduler in the rtc_clk domain, downstream of the rx/tx timestamp unit.
- Queues completed rx and tx PTP timestamp records in two independent FIFOs.
- Arbitrates them round-robin onto one valid/ready readout port, which feeds the register/CPU interface, so that back-to-back frames do not overwrite captured timestamps.
- Provides occupancy, drop counters and a level interrupt.

Parameters:
DEPTH_LOG2, 2, log2 of each FIFO depth (depth = 4 records per direction)
DROP_W, 8, width of saturating drop counters

Ports:
rtc_clk  input  1  single clock for the whole block
rtc_rst  input  1  asynchronous reset, active-high
flush_i  input  1  synchronous clear of both FIFOs, output stage and drop counters
int_en_i  input  1  interrupt enable
rx_ts_stb_i  input  1  one-cycle pulse; rx record fields valid this cycle
rx_timestamp_i  input  80  48b seconds + 32b ns
rx_frac_ns_i  input  16  fractional ns
rx_seqId_i  input  16  PTP sequenceId
rx_messageType_i  input  4  PTP messageType
tx_ts_stb_i, tx_timestamp_i, tx_frac_ns_i, tx_seqId_i, tx_messageType_i  input  1/80/16/16/4  tx equivalents
rd_valid_o  output  1  readout record valid
rd_ready_i  input  1  consumer accepts record
rd_dir_o  output  1  0 = rx, 1 = tx
rd_timestamp_o  output  80  record timestamp
rd_frac_ns_o  output  16  record fractional ns
rd_seqId_o  output  16  record sequenceId
rd_messageType_o  output  4  record messageType
rx_level_o, tx_level_o  output  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2
rx_drop_cnt_o, tx_drop_cnt_o  output  DROP_W  records dropped on full, saturating
int_ts_o  output  1  rd_valid_o & int_en_i, combinational level

Behaviour:
- Reset (rtc_rst high, async): all outputs 0, FIFO pointers 0, last_grant = tx (first grant goes to rx), output stage EMPTY.
- Record width: 116 bits (80 + 16 + 16 + 4). Direction is implied by the FIFO it sits in and is attached when the record is loaded into the output register.
- Push: a strobe at edge N writes the record at that edge. The level increments after edge N.
- Full:
  - Strobe while full with no pop from that FIFO in the same cycle → record discarded, drop counter +1, saturating at 2^DROP_W−1.
  - Strobe while full with a pop from that FIFO in the same cycle → accepted, level unchanged.
- Output stage has two states:
  - EMPTY: rd_valid_o = 0.
  - HOLD: rd_valid_o = 1; all rd_* fields stable until handshake.
- Load condition: EMPTY, or HOLD with rd_valid_o & rd_ready_i. If either FIFO is non-empty, pop one record into the output register and go to HOLD; else go to EMPTY.
- Grant rules:
  - Both FIFOs non-empty → grant the direction opposite last_grant.
  - One FIFO non-empty → grant that one.
  - last_grant updates on every pop.
- Latency: strobe at edge N into an empty block → rd_valid_o high after edge N+1 (2 cycles). Sustained throughput is 1 record/cycle with rd_ready_i held high.
- Push to an empty FIFO is not bypassed; a record is only loaded from FIFO contents as of the previous edge.
- Simultaneous rx and tx strobes: both accepted independently.
- flush_i:
  - Has priority over everything in the same cycle.
  - Strobes that cycle are discarded without counting.
  - Next state: levels 0, drop counters 0, EMPTY, last_grant = tx.
- Pointer wrap: modulo 2^DEPTH_LOG2. Full/empty are derived from the extra pointer MSB.
- Reset mid-transfer: the record is lost and no partial state is retained.

Optional Feature:
TS_EVENT_FILTER_EN
- Defined: only event messages (messageType 0..3: Sync, Delay_Req, Pdelay_Req, Pdelay_Resp) are enqueued. Strobes carrying other types are ignored and are not counted as drops.
- Undefined: every strobe is enqueued regardless of messageType.

Test Plan:
- Reset, then single rx strobe (ts = 0x000000000005_3B9AC9FF, seqId = 0x0007, type = 0) with rd_ready_i = 0 → rd_valid_o = 1 two cycles later, rd_dir_o = 0, fields match exactly, int_ts_o = 1 only with int_en_i = 1; record holds until rd_ready_i = 1.
- rx and tx strobes in the same cycle (seqId 0x0010 / 0x0020), rd_ready_i = 1 → rx record is read first, tx on the next cycle; last_grant alternates over 4 further paired strobes.
- 6 rx strobes with rd_ready_i = 0 (depth 4, output holding 1) → rx_level_o = 4, rx_drop_cnt_o = 1, readout order = seqIds 1..5.
- Full rx FIFO with rd_ready_i = 1 and a strobe in the same cycle → no drop, rx_level_o stays 4.
- Drive 300 drops → rx_drop_cnt_o saturates at 255; then flush_i together with a tx strobe → next cycle all levels/counters 0, rd_valid_o = 0, tx record not queued.
- With TS_EVENT_FILTER_EN, strobe type 0x8 (Follow_Up) then type 0x1 → only seqId of type 0x1 read out, drop counters 0; without the macro both records are read out.
